psram_linefill_ctrl: RTL and testbench
======================================

Name: psram_linefill_ctrl

Overview:
- Sits between the L1 cache miss path and memory_controller_burst.
- Turns a cache miss into one aligned burst read of a full line, and streams the returned words to the cache with an index.
- Also forwards single-word write-through stores as non-burst writes.
- Drives the controller's one-cycle command pulse and decodes its ready-based word return.

Parameters:
- LINE_WORDS, 8: words per cache line; power of two, 2..64.
- TIMEOUT_CYCLES, 4096: cycles allowed per wait phase before an error is flagged; used only with the optional feature.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  cache request present; held until accepted.
- req_we  in  1  1 = single-word write, 0 = line fill.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_ready  out  1  request accepted in any cycle where req_valid && req_ready.
- fill_valid  out  1  one-cycle strobe: fill_data is valid.
- fill_data  out  32  returned word.
- fill_idx  out  log2(LINE_WORDS)  word index within the line.
- fill_last  out  1  asserted with the final fill_valid of a line.
- wr_done  out  1  one-cycle pulse when a write completes.
- err  out  1  one-cycle pulse on timeout (optional feature only).
- mc_burst_en  out  1  to controller burst_en.
- mc_burst_length  out  8  to controller burst_length.
- mc_a  out  32  to controller a.
- mc_d  out  32  to controller d.
- mc_we  out  1  to controller we.
- mc_rd  out  1  to controller rd.
- mc_spo  in  32  from controller spo.
- mc_ready  in  1  from controller ready.

Behaviour:
- Reset (rst=0 at a posedge):
  - state to IDLE.
  - All mc_* outputs, fill_*, wr_done and err go to 0.
  - req_ready goes to 0.
  - Word counter is cleared.
  - Reset mid-burst abandons the burst; no fill_valid is issued afterwards.
- req_ready = 1 only when state==IDLE && mc_ready==1 (registered). A request is never accepted while the controller is busy.
- Command pulse:
  - mc_rd or mc_we, plus mc_burst_en and mc_burst_length, are high for exactly one clk cycle (state ISSUE).
  - Outside ISSUE, all mc_* outputs are 0.
- Read address and length:
  - mc_a = req_addr with bits [log2(LINE_WORDS)+1:0] cleared.
  - mc_burst_length = LINE_WORDS.
- Write command: mc_burst_en=0, mc_burst_length=0, mc_a=req_addr, mc_d=req_wdata, mc_we=1.
- States:
  - IDLE: accept request, latch address and data, go to ISSUE.
  - ISSUE: drive the command for one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for mc_ready==0. Then go to COLLECT for a read, or WRITE_WAIT for a write.
  - COLLECT: a word is detected on each rising edge of mc_ready, i.e. mc_ready==1 and mc_ready was 0 the previous cycle.
    - On each detected word, register mc_spo into fill_data and the counter into fill_idx, and pulse fill_valid one cycle later.
    - Increment the counter.
    - The word at count LINE_WORDS-1 also sets fill_last, then goes to IDLE.
  - WRITE_WAIT: when mc_ready==1, pulse wr_done and go to IDLE.
- Additional rising edges after the last word are ignored (the state is already IDLE).
- The word counter is log2(LINE_WORDS) bits and wraps to 0 after the last word.
- Latency:
  - Request acceptance to command pulse: 1 cycle.
  - Controller word edge to fill_valid: 1 cycle.
- The first cycle back in IDLE may already assert req_ready if mc_ready==1, giving back-to-back requests.

Optional Feature:
- Macro: LINEFILL_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter resets at entry to each of WAIT_BUSY, COLLECT and WRITE_WAIT, and at each detected word.
  - If the counter reaches TIMEOUT_CYCLES, pulse err for 1 cycle and go to IDLE without fill_last or wr_done.
- Without the macro: no counter is built, err is tied to 0, and the block waits indefinitely.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> all outputs 0, no mc_rd pulse; after release with mc_ready=1, req_ready=1 on the next cycle.
- Line fill: read req_addr=32'h2000abcd, LINE_WORDS=8 ->
  - one-cycle mc_rd=1, mc_burst_en=1, mc_burst_length=8, mc_a=32'h2000abc0;
  - model returns 8 ready edges with spo=32'hdead0000+i;
  - fill_idx runs 0..7, fill_data matches, and fill_last is set only at idx 7.
- Write: req_we=1, addr=32'h00001004, wdata=32'hdeadbeef -> one-cycle mc_we=1 with mc_burst_en=0 and mc_d=32'hdeadbeef; a single wr_done after mc_ready returns high.
- Busy controller: request while mc_ready=0 -> req_ready stays 0 and no command is issued until mc_ready=1.
- Reset mid-burst: assert rst=0 after 3 of 8 words -> no further fill_valid; the next request starts with fill_idx=0.
- Timeout (LINEFILL_TIMEOUT_EN, TIMEOUT_CYCLES=16): controller never drops ready -> err pulses once 16 cycles after WAIT_BUSY entry and the block returns to IDLE; without the macro, err stays 0.

Source files
------------

// File: rtl/psram_linefill_ctrl.sv
// Cache line-fill and write-through bridge onto memory_controller_burst's pulse/ready interface.
// Optional per-phase watchdog is compiled in with `define LINEFILL_TIMEOUT_EN.
module psram_linefill_ctrl #(
  parameter int LINE_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic                          req_we,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          req_ready,
  output logic                          fill_valid,
  output logic [31:0]                   fill_data,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic                          fill_last,
  output logic                          wr_done,
  output logic                          err,
  output logic                          mc_burst_en,
  output logic [7:0]                    mc_burst_length,
  output logic [31:0]                   mc_a,
  output logic [31:0]                   mc_d,
  output logic                          mc_we,
  output logic                          mc_rd,
  input  logic [31:0]                   mc_spo,
  input  logic                          mc_ready
);

  localparam int               IW        = $clog2(LINE_WORDS);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(LINE_WORDS - 1);
  localparam logic [IW-1:0]    CNT_ONE   = IW'(1);
  localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [7:0]       BURST_LEN = 8'(LINE_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_BUSY  = 3'd2,
    ST_COLLECT    = 3'd3,
    ST_WRITE_WAIT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_req_ready;
  logic            r_is_write;
  logic            r_ready_d;
  logic [IW-1:0]   r_cnt;
  logic            r_fill_valid;
  logic [31:0]     r_fill_data;
  logic [IW-1:0]   r_fill_idx;
  logic            r_fill_last;
  logic            r_wr_done;
  logic            r_err;
  logic            r_mc_burst_en;
  logic [7:0]      r_mc_burst_length;
  logic [31:0]     r_mc_a;
  logic [31:0]     r_mc_d;
  logic            r_mc_we;
  logic            r_mc_rd;

  logic            w_accept;
  logic            w_word;
  logic            w_wr_fin;
  logic            w_tmo;
  logic            w_tmo_hit;

  // Next-state decode; a word is a 0->1 transition of mc_ready while collecting.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_word      = 1'b0;
    w_wr_fin    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!mc_ready) begin
          w_state_nxt = r_is_write ? ST_WRITE_WAIT : ST_COLLECT;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_COLLECT: begin
        if (mc_ready && !r_ready_d) begin
          w_word      = 1'b1;
          w_state_nxt = (r_cnt == LAST_IDX) ? ST_IDLE : ST_COLLECT;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_WRITE_WAIT: begin
        if (mc_ready) begin
          w_wr_fin    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WRITE_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state           <= ST_IDLE;
      r_req_ready       <= 1'b0;
      r_is_write        <= 1'b0;
      r_ready_d         <= 1'b0;
      r_cnt             <= '0;
      r_fill_valid      <= 1'b0;
      r_fill_data       <= 32'd0;
      r_fill_idx        <= '0;
      r_fill_last       <= 1'b0;
      r_wr_done         <= 1'b0;
      r_err             <= 1'b0;
      r_mc_burst_en     <= 1'b0;
      r_mc_burst_length <= 8'd0;
      r_mc_a            <= 32'd0;
      r_mc_d            <= 32'd0;
      r_mc_we           <= 1'b0;
      r_mc_rd           <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready_d    <= mc_ready;
      // Looking at the next state lets the first IDLE cycle already accept.
      r_req_ready  <= (w_state_nxt == ST_IDLE) && mc_ready;
      r_fill_valid <= w_word;
      r_fill_last  <= w_word && (r_cnt == LAST_IDX);
      r_wr_done    <= w_wr_fin;
      r_err        <= w_tmo;
      if (w_word) begin
        r_fill_data <= mc_spo;
        r_fill_idx  <= r_cnt;
      end else begin
        r_fill_data <= r_fill_data;
        r_fill_idx  <= r_fill_idx;
      end
      if (w_accept) begin
        r_is_write        <= req_we;
        r_cnt             <= '0;
        r_mc_rd           <= ~req_we;
        r_mc_we           <= req_we;
        r_mc_burst_en     <= ~req_we;
        r_mc_burst_length <= req_we ? 8'd0 : BURST_LEN;
        r_mc_a            <= req_we ? req_addr : (req_addr & ADDR_MASK);
        r_mc_d            <= req_we ? req_wdata : 32'd0;
      end else begin
        r_is_write        <= r_is_write;
        r_cnt             <= w_word ? (r_cnt + CNT_ONE) : r_cnt;
        r_mc_rd           <= 1'b0;
        r_mc_we           <= 1'b0;
        r_mc_burst_en     <= 1'b0;
        r_mc_burst_length <= 8'd0;
        r_mc_a            <= 32'd0;
        r_mc_d            <= 32'd0;
      end
    end
  end

`ifdef LINEFILL_TIMEOUT_EN
  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);

  logic [TW-1:0] r_tmo_cnt;

  // Phase watchdog: restarts on every state change and on every received word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if ((w_state_nxt != r_state) || w_word) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TMO_LAST) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`else
  // Watchdog absent: this compare is constant false, so err never fires.
  assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign req_ready       = r_req_ready;
  assign fill_valid      = r_fill_valid;
  assign fill_data       = r_fill_data;
  assign fill_idx        = r_fill_idx;
  assign fill_last       = r_fill_last;
  assign wr_done         = r_wr_done;
  assign err             = r_err;
  assign mc_burst_en     = r_mc_burst_en;
  assign mc_burst_length = r_mc_burst_length;
  assign mc_a            = r_mc_a;
  assign mc_d            = r_mc_d;
  assign mc_we           = r_mc_we;
  assign mc_rd           = r_mc_rd;

endmodule

// File: tb/tb_psram_linefill_ctrl.sv
// Scoreboard bench for psram_linefill_ctrl with a behavioural burst-controller model.
module tb_psram_linefill_ctrl;
  localparam int LW  = 8;
  localparam int IW  = $clog2(LW);
  localparam int TMO = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  typedef struct packed {
    logic [31:0]   d;
    logic [IW-1:0] idx;
    logic          last;
  } fill_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          fill_valid;
  logic [31:0]   fill_data;
  logic [IW-1:0] fill_idx;
  logic          fill_last;
  logic          wr_done;
  logic          err;
  logic          mc_burst_en;
  logic [7:0]    mc_burst_length;
  logic [31:0]   mc_a;
  logic [31:0]   mc_d;
  logic          mc_we;
  logic          mc_rd;
  logic [31:0]   mc_spo;
  logic          mc_ready;

  cmd_t  cmd_q[$];
  fill_t fill_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    fills_seen = 0;
  int    wr_seen    = 0;
  int    exp_wr     = 0;
  int    err_cnt    = 0;
  int    err_cyc    = 0;
  int    cmd_cyc    = 0;
  logic  model_busy  = 1'b0;
  logic  model_stuck = 1'b0;
  int    model_words = LW;
  logic [31:0] data_base = 32'hdead0000;

  psram_linefill_ctrl #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_idx(fill_idx), .fill_last(fill_last),
    .wr_done(wr_done), .err(err),
    .mc_burst_en(mc_burst_en), .mc_burst_length(mc_burst_length), .mc_a(mc_a), .mc_d(mc_d),
    .mc_we(mc_we), .mc_rd(mc_rd), .mc_spo(mc_spo), .mc_ready(mc_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: ready drops after a command, each word is a 0->1 ready edge.
  initial begin : ctrl_model
    mc_ready = 1'b1;
    mc_spo   = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (model_busy) begin
        mc_ready = 1'b0;
      end else if (model_stuck) begin
        mc_ready = 1'b1;
      end else if (mc_rd) begin
        @(posedge clk);
        #1;
        mc_ready = 1'b0;
        for (int i = 0; i < model_words; i++) begin
          repeat (2) @(posedge clk);
          #1;
          mc_spo   = data_base + 32'(i);
          mc_ready = 1'b1;
          fill_q.push_back(fill_t'{d: data_base + 32'(i), idx: IW'(i), last: (i == LW - 1)});
          @(posedge clk);
          #1;
          if (i != model_words - 1) mc_ready = 1'b0;
        end
        mc_ready = 1'b1;
      end else if (mc_we) begin
        @(posedge clk);
        #1;
        mc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mc_ready = 1'b1;
        exp_wr++;
      end else begin
        mc_ready = 1'b1;
      end
    end
  end

  // Output monitor: commands, fills and write completions against the scoreboard.
  initial begin : monitor
    cmd_t  c;
    fill_t f;
    logic  prev_cmd;
    prev_cmd = 1'b0;
    forever begin
      @(negedge clk);
      if (mc_rd || mc_we) begin
        check_eq("cmd_one_cycle", 128'(prev_cmd), 128'd0);
        check_eq("cmd_expected", 128'(cmd_q.size() != 0), 128'd1);
        if (cmd_q.size() != 0) begin
          c = cmd_q.pop_front();
          cmd_cyc = cyc;
          check_eq("cmd_ctrl", {mc_rd, mc_we, mc_burst_en, mc_burst_length},
                   {~c.we, c.we, ~c.we, (c.we ? 8'd0 : 8'(LW))});
          check_eq("cmd_addr", mc_a, c.a);
          if (c.we) check_eq("cmd_wdata", mc_d, c.d);
        end
      end else begin
        check_eq("mc_idle", {mc_burst_en, mc_burst_length, mc_a, mc_d}, 128'd0);
      end
      prev_cmd = mc_rd || mc_we;
      if (fill_valid) begin
        fills_seen++;
        check_eq("fill_expected", 128'(fill_q.size() != 0), 128'd1);
        if (fill_q.size() != 0) begin
          f = fill_q.pop_front();
          check_eq("fill_word", {fill_data, fill_idx, fill_last}, {f.d, f.idx, f.last});
        end
      end else begin
        check_eq("fill_last_alone", 128'(fill_last), 128'd0);
      end
      if (wr_done) begin
        wr_seen++;
        check_eq("wr_done_expected", 128'(exp_wr > 0), 128'd1);
        if (exp_wr > 0) exp_wr--;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_a);
    int k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("req_accept", 128'(req_ready), 128'd1);
    cmd_q.push_back(cmd_t'{we: we, a: exp_a, d: wdata});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_fills(input int target);
    for (int k = 0; k < 400 && fills_seen < target; k++) @(negedge clk);
    check_eq("fill_count", 128'(fills_seen), 128'(target));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin : main
    int base;
    rst       = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h2000abcd;
    req_wdata = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_ctrl", {req_ready, fill_valid, fill_last, wr_done, err, mc_rd, mc_we, mc_burst_en},
               128'd0);
      check_eq("rst_fill", {fill_data, fill_idx}, 128'd0);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel_req_ready", 128'(req_ready), 128'd1);

    // Aligned line fill
    base = fills_seen;
    do_req(1'b0, 32'h2000abcd, 32'd0, 32'h2000abc0);
    wait_fills(base + LW);

    // Write-through store
    base = wr_seen;
    do_req(1'b1, 32'h00001004, 32'hdeadbeef, 32'h00001004);
    for (int k = 0; k < 50 && wr_seen == base; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    check_eq("wr_done_count", 128'(wr_seen - base), 128'd1);

    // Busy controller holds off acceptance
    model_busy = 1'b1;
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h00000044;
    repeat (5) begin
      @(negedge clk);
      check_eq("busy_req_ready", 128'(req_ready), 128'd0);
    end
    model_busy = 1'b0;
    data_base  = 32'h12340000;
    base = fills_seen;
    do_req(1'b0, 32'h00000044, 32'd0, 32'h00000040);
    wait_fills(base + LW);

    // Reset after three words abandons the burst
    model_words = 3;
    data_base   = 32'hdead0000;
    base = fills_seen;
    do_req(1'b0, 32'h2000abcd, 32'd0, 32'h2000abc0);
    wait_fills(base + 3);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("mid_rst_no_fill", 128'(fills_seen), 128'(base + 3));
    model_words = LW;
    data_base   = 32'h0badf000;
    base = fills_seen;
    do_req(1'b0, 32'h00000100, 32'd0, 32'h00000100);
    wait_fills(base + LW);

    // Controller never drops ready
    model_stuck = 1'b1;
    repeat (2) @(negedge clk);
    do_req(1'b0, 32'h00000200, 32'd0, 32'h00000200);
    repeat (40) @(negedge clk);
`ifdef LINEFILL_TIMEOUT_EN
    check_eq("tmo_err_count", 128'(err_cnt), 128'd1);
    check_eq("tmo_err_delay", 128'(err_cyc - cmd_cyc), 128'(TMO + 1));
    check_eq("tmo_back_idle", 128'(req_ready), 128'd1);
`else
    check_eq("no_tmo_err", 128'(err_cnt), 128'd0);
    check_eq("no_tmo_stalled", 128'(req_ready), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif
    model_stuck = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("final_req_ready", 128'(req_ready), 128'd1);
    check_eq("cmd_q_empty", 128'(cmd_q.size()), 128'd0);
    check_eq("fill_q_empty", 128'(fill_q.size()), 128'd0);
    check_eq("wr_pending", 128'(exp_wr), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
